stepcount_sched: RTL and testbench

- Controller and arbiter that shares one step-accumulating counter between two requesters.
- Each requester supplies a step size and a stop limit.
- The scheduler grants the counter round-robin, clears it, and sequences the accumulation until the limit or an overflow is reached.
- It reports completion, the final count, a threshold flag and an overflow flag; it sits between requester logic and the counter datapath.

---
 rtl/stepcount_pkg.sv | 8 +
 rtl/stepcount_rr_arb2.sv | 10 +
 rtl/stepcount_sched.sv | 77 +++++++
 tb/tb_stepcount_sched.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/stepcount_pkg.sv
// stepcount_pkg: shared state type, default sizing and requester indices for the step-count scheduler
package stepcount_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 4;
  localparam int THRESH_DEF = 10;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/stepcount_rr_arb2.sv
// stepcount_rr_arb2: combinational 2-way round-robin pick; ptr names the preferred requester
module stepcount_rr_arb2 import stepcount_pkg::*; (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  always_comb win = ~|req ? 2'b00 :
                    req[ptr] ? (ptr == REQ1 ? 2'b10 : 2'b01) :
                    (ptr == REQ1 ? 2'b01 : 2'b10);
endmodule

// File: rtl/stepcount_sched.sv
// stepcount_sched: round-robin owner of a shared step-accumulating counter; runs a job to limit or carry-out
module stepcount_sched import stepcount_pkg::*; #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] step0,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] step1,
  input  logic [WIDTH-1:0] limit1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             hi,
  output logic             ovf
);
  state_t           state;
  logic             ptr;
  logic [WIDTH-1:0] stp;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] nstp;
  logic [1:0]       win;
  logic [WIDTH:0]   sum;
  stepcount_rr_arb2 u_arb (.req(req), .ptr(ptr), .win(win));
  always_comb begin
    sum  = {1'b0, count} + {1'b0, stp};
    nstp = win[1] ? step1 : step0;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      count <= '0;
      hi    <= 1'b0;
      ovf   <= 1'b0;
      ptr   <= REQ0;
      stp   <= '0;
      lim   <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= RUN;
          gnt   <= win;
          count <= '0;
          stp   <= nstp == '0 ? WIDTH'(1) : nstp;
          lim   <= win[1] ? limit1 : limit0;
        end
        RUN: if (~|(req & gnt)) begin
          // owner withdrew: release silently, keep the partial count
          state <= IDLE;
          gnt   <= '0;
          ptr   <= gnt[0];
        end else begin
          count <= sum[WIDTH-1:0];
          if (sum[WIDTH] || sum >= {1'b0, lim}) begin
            state <= DONE;
            ovf   <= sum[WIDTH];
            hi    <= int'(sum[WIDTH-1:0]) >= THRESH;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          hi    <= 1'b0;
          ovf   <= 1'b0;
          ptr   <= gnt[0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stepcount_sched.sv
// tb_stepcount_sched: scoreboard bench; jobs push expected results, a monitor checks every done pulse
module tb_stepcount_sched;
  logic       clk, rst;
  logic [1:0] req;
  logic [3:0] step0, limit0, step1, limit1;
  logic [1:0] gnt;
  logic       busy, done, hi, ovf;
  logic [3:0] count;

  typedef struct {logic [1:0] g; logic [3:0] c; logic h; logic o;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int ptr_m = 0;

  stepcount_sched dut (.clk(clk), .rst(rst), .req(req), .step0(step0), .limit0(limit0),
    .step1(step1), .limit1(limit1), .gnt(gnt), .busy(busy), .done(done), .count(count),
    .hi(hi), .ovf(ovf));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // expected job outcome from plain arithmetic: ceil(limit/step) adds, or the first add that exceeds 15
  function automatic exp_t model(input int w, input int s, input int l);
    exp_t e;
    int n, fin, c;
    n = (l == 0) ? 1 : (l + s - 1) / s;
    fin = n * s;
    e.o = fin > 15;
    c = e.o ? ((15 / s + 1) * s) % 16 : fin;
    e.c = c[3:0];
    e.h = c >= 10;
    e.g = w ? 2'b10 : 2'b01;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_gnt", gnt, e.g);
        chk("done_count", count, e.c);
        chk("done_hi", hi, e.h);
        chk("done_ovf", ovf, e.o);
      end
    end
  end

  task automatic job(input logic [1:0] r, input logic [3:0] a0, input logic [3:0] b0,
                     input logic [3:0] a1, input logic [3:0] b1, input bit hold, output int wt);
    int w, s, l, k;
    bit got;
    step0 = a0; limit0 = b0; step1 = a1; limit1 = b1; req = r;
    w = r[ptr_m] ? ptr_m : 1 - ptr_m;
    s = w ? int'(a1) : int'(a0);
    if (s == 0) s = 1;
    l = w ? int'(b1) : int'(b0);
    q.push_back(model(w, s, l));
    got = 0; wt = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      wt++;
      got = gnt != 0;
    end
    chk("grant", gnt, w ? 2 : 1);
    if (got) begin
      step0 = 4'($urandom); limit0 = 4'($urandom); step1 = 4'($urandom); limit1 = 4'($urandom);
      k = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        k++;
        got = done;
        if (!done) chk("run_count", count, k * s);
      end
      chk("done_seen", got, 1);
    end
    if (!hold) req = 0;
    ptr_m = 1 - w;
  endtask

  initial begin
    int wt;
    bit got;
    rst = 0; req = 0; step0 = 0; limit0 = 0; step1 = 0; limit1 = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt, busy, done, count, hi, ovf}, 0);
    rst = 1;
    @(negedge clk);
    job(2'b01, 3, 10, 0, 0, 0, wt);
    job(2'b10, 0, 0, 5, 15, 0, wt);
    job(2'b01, 7, 15, 0, 0, 0, wt);
    for (int j = 0; j < 3; j++) begin
      job(2'b11, 4, 8, 4, 8, 1, wt);
      if (j > 0) chk("b2b_spacing", wt, 2);
    end
    req = 0;
    @(negedge clk);
    // abort: owner drops after three adds of step 1
    step0 = 1; limit0 = 15; req = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = gnt != 0; end
    chk("abort_grant", gnt, 1);
    repeat (3) @(negedge clk);
    chk("abort_pre_count", count, 3);
    req = 0;
    @(negedge clk);
    chk("abort_idle", {gnt, busy, done}, 0);
    chk("abort_count", count, 3);
    ptr_m = 1;
    job(2'b11, 2, 5, 3, 9, 0, wt);
    for (int j = 0; j < 25; j++)
      job(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0, wt);
    @(negedge clk);
    // asynchronous reset mid-run at count 6
    step0 = 3; limit0 = 15; req = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = count == 6 && busy; end
    chk("pre_reset_count", count, 6);
    #2 rst = 0;
    #1 chk("async_reset_outputs", {gnt, busy, done, count, hi, ovf}, 0);
    req = 0;
    q.delete();
    ptr_m = 0;
    @(negedge clk);
    rst = 1;
    job(2'b10, 3, 15, 5, 15, 0, wt);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
